pc_sequencer: RTL and testbench

Next-PC controller that sits directly in front of the PC register and computes the value it loads every cycle. It arbitrates between sequential fetch, branch/jump redirects from ID, exception entry and ERET return. It also holds the PC during hazard stalls and instruction-memory wait states. A redirect that arrives while fetch is frozen is buffered until the delay slot has been fetched, and a watchdog counter converts a hung instruction fetch into an exception.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller placed in front of the PC register.
// Chooses between sequential fetch, ID redirects, exception entry and ERET.
// It holds the PC during stalls and memory wait states. A redirect seen
// while fetch is frozen is buffered until the next advance. A watchdog turns
// a hung instruction fetch into a bus-error exception.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_PC      = 32'h0000_4180,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Pc,
  output logic [31:0] NPC,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic        Redirect,
  input  logic [31:0] RedirTarget,
  input  logic        ExcReq,
  input  logic        Eret,
  input  logic [31:0] Epc,
  output logic        FetchValid,
  output logic        FlushIFID,
  output logic        AlignErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] pbuf_q, pbuf_d;
  logic [7:0]  wcnt_q, wcnt_d;

  // Candidate redirect/return target that still has to pass the alignment check.
  logic        use_tgt;
  logic [31:0] tgt;
  logic        timeout;

  // The MEM_TIMEOUT-th consecutive not-ready cycle fires the watchdog.
  assign timeout = (wcnt_q == (MEM_TIMEOUT - 8'd1)) && !ImemReady;

  // Next-PC selection, flag generation and next-state computation.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    pend_d     = pend_q;
    pbuf_d     = pbuf_q;
    wcnt_d     = wcnt_q;
    NPC        = RESET_PC;
    FetchValid = 1'b0;
    FlushIFID  = 1'b0;
    AlignErr   = 1'b0;
    BusErr     = 1'b0;
    use_tgt    = 1'b0;
    tgt        = '0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      default: begin
        if (ExcReq || timeout) begin
          // Exception entry wins over everything; a same-cycle redirect is dropped.
          NPC       = EXC_PC;
          FlushIFID = 1'b1;
          BusErr    = !ExcReq;
          pend_d    = 1'b0;
          wcnt_d    = '0;
          state_d   = RUN;
        end else if (Eret) begin
          use_tgt   = 1'b1;
          tgt       = Epc;
          FlushIFID = 1'b1;
          pend_d    = 1'b0;
          wcnt_d    = '0;
          state_d   = RUN;
        end else if (Stall || !ImemReady) begin
          // Frozen: hold the PC and remember only the most recent redirect.
          NPC = Pc;
          if (Redirect) begin
            pbuf_d = RedirTarget;
            pend_d = 1'b1;
          end
          if (!ImemReady) begin
            wcnt_d  = wcnt_q + 8'd1;
            state_d = WAIT_MEM;
          end else begin
            wcnt_d  = '0;
            state_d = RUN;
          end
        end else begin
          FetchValid = 1'b1;
          wcnt_d     = '0;
          pend_d     = 1'b0;
          state_d    = RUN;
          if (Redirect) begin
            use_tgt = 1'b1;
            tgt     = RedirTarget;
          end else if (pend_q) begin
            use_tgt = 1'b1;
            tgt     = pbuf_q;
          end else begin
            // Sequential path wraps modulo 2^32 and is never alignment-checked.
            NPC = Pc + 32'd4;
          end
        end

        if (use_tgt) begin
          if (tgt[1:0] != 2'b00) begin
            NPC        = EXC_PC;
            AlignErr   = 1'b1;
            FlushIFID  = 1'b1;
            FetchValid = 1'b0;
            pend_d     = 1'b0;
          end else begin
            NPC = tgt;
          end
        end
      end
    endcase
  end

  // State and buffered-redirect registers; reset discards any pending target.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BOOT;
      pend_q  <= 1'b0;
      pbuf_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      pend_q  <= pend_d;
      pbuf_q  <= pbuf_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic for pc_sequencer,
// checked against a behavioural next-PC model kept in the bench.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam logic [7:0]  MT     = 8'd4;

  logic        Clk, Reset_n;
  logic [31:0] Pc, NPC, RedirTarget, Epc;
  logic        Stall, ImemReady, Redirect, ExcReq, Eret;
  logic        FetchValid, FlushIFID, AlignErr, BusErr;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: "just left reset", buffered redirect, not-ready run length.
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_pbuf;
  int          m_wcnt;
  // Model next state and expected outputs for the current cycle.
  bit          n_boot, n_pend;
  logic [31:0] n_pbuf;
  int          n_wcnt;
  logic [31:0] e_npc;
  bit          e_fv, e_fl, e_ae, e_be;
  // DUT outputs sampled mid-cycle.
  logic [31:0] o_npc;
  logic        o_fv, o_fl, o_ae, o_be;

  pc_sequencer #(
    .RESET_PC   (RST_PC),
    .EXC_PC     (EXC_PC),
    .MEM_TIMEOUT(MT)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Pc         (Pc),
    .NPC        (NPC),
    .Stall      (Stall),
    .ImemReady  (ImemReady),
    .Redirect   (Redirect),
    .RedirTarget(RedirTarget),
    .ExcReq     (ExcReq),
    .Eret       (Eret),
    .Epc        (Epc),
    .FetchValid (FetchValid),
    .FlushIFID  (FlushIFID),
    .AlignErr   (AlignErr),
    .BusErr     (BusErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_in(input bit stall, input bit ready, input bit redir,
                        input logic [31:0] rt, input bit exc, input bit eret,
                        input logic [31:0] epc, input logic [31:0] pc);
    Stall = stall; ImemReady = ready; Redirect = redir; RedirTarget = rt;
    ExcReq = exc; Eret = eret; Epc = epc; Pc = pc;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_pend = 1'b0; m_pbuf = '0; m_wcnt = 0;
  endtask

  // Redirect-style target: take it if word aligned, else vector to EXC_PC.
  task automatic apply_target(input logic [31:0] t, input bit fetch);
    if (t[1:0] != 2'b00) begin
      e_npc = EXC_PC; e_ae = 1'b1; e_fl = 1'b1; e_fv = 1'b0; n_pend = 1'b0;
    end else begin
      e_npc = t; e_fv = fetch;
    end
  endtask

  // Behavioural next-PC rules in priority order.
  task automatic model_eval();
    n_boot = 1'b0; n_pend = m_pend; n_pbuf = m_pbuf; n_wcnt = m_wcnt;
    e_npc = RST_PC; e_fv = 0; e_fl = 0; e_ae = 0; e_be = 0;
    if (m_boot) begin
      e_npc = RST_PC;
    end else if (ExcReq || (m_wcnt == int'(MT) - 1 && !ImemReady)) begin
      e_npc = EXC_PC; e_fl = 1; e_be = !ExcReq; n_pend = 0; n_wcnt = 0;
    end else if (Eret) begin
      e_fl = 1; n_pend = 0; n_wcnt = 0;
      apply_target(Epc, 1'b0);
    end else if (Stall || !ImemReady) begin
      e_npc = Pc;
      if (Redirect) begin n_pend = 1; n_pbuf = RedirTarget; end
      n_wcnt = ImemReady ? 0 : m_wcnt + 1;
    end else begin
      n_wcnt = 0; n_pend = 0;
      if (Redirect)    apply_target(RedirTarget, 1'b1);
      else if (m_pend) apply_target(m_pbuf, 1'b1);
      else begin e_npc = Pc + 32'd4; e_fv = 1; end
    end
  endtask

  // One clocked cycle: inputs already driven; sample, compare, advance model.
  task automatic cycle(input string tag);
    #3;
    model_eval();
    o_npc = NPC; o_fv = FetchValid; o_fl = FlushIFID; o_ae = AlignErr; o_be = BusErr;
    check({tag, ".npc"}, o_npc, e_npc);
    check({tag, ".fv"},  {31'd0, o_fv}, {31'd0, e_fv});
    check({tag, ".fl"},  {31'd0, o_fl}, {31'd0, e_fl});
    check({tag, ".ae"},  {31'd0, o_ae}, {31'd0, e_ae});
    check({tag, ".be"},  {31'd0, o_be}, {31'd0, e_be});
    @(posedge Clk);
    #1;
    m_boot = n_boot; m_pend = n_pend; m_pbuf = n_pbuf; m_wcnt = n_wcnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".npc"}, NPC, RST_PC);
    check({tag, ".flags"}, {28'd0, FetchValid, FlushIFID, AlignErr, BusErr}, 32'd0);
  endtask

  logic [31:0] pc_next;
  logic [31:0] rt_r, epc_r;

  initial begin
    Reset_n = 1'b0;
    set_in(0, 1, 0, '0, 0, 0, '0, '0);
    model_reset();

    // Reset held low, then one BOOT cycle, then the first fetch.
    repeat (2) begin
      @(posedge Clk); #1;
      check_reset_outputs("rst_hold");
    end
    Reset_n = 1'b1;
    cycle("boot");
    check("boot.npc", o_npc, RST_PC);
    check("boot.fv", {31'd0, o_fv}, 32'd0);
    set_in(0, 1, 0, '0, 0, 0, '0, 32'h3000);
    cycle("first");
    check("first.npc", o_npc, 32'h3004);
    check("first.fv", {31'd0, o_fv}, 32'd1);

    // Redirect buffered across a three-cycle stall, applied on the advance.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 32'h3040, 0, 0, '0, 32'h3008);
      cycle("buf_hold");
      check("buf_hold.npc", o_npc, 32'h3008);
      check("buf_hold.fv", {31'd0, o_fv}, 32'd0);
    end
    set_in(0, 1, 0, '0, 0, 0, '0, 32'h3008);
    cycle("buf_apply");
    check("buf_apply.npc", o_npc, 32'h3040);
    check("buf_apply.fv", {31'd0, o_fv}, 32'd1);
    set_in(0, 1, 0, '0, 0, 0, '0, 32'h3040);
    cycle("buf_after");
    check("buf_after.npc", o_npc, 32'h3044);

    // ExcReq beats Redirect, Eret and Stall; the redirect is not buffered.
    set_in(1, 1, 1, 32'h3080, 1, 1, 32'h3100, 32'h3044);
    cycle("prio");
    check("prio.npc", o_npc, EXC_PC);
    check("prio.fl", {31'd0, o_fl}, 32'd1);
    set_in(0, 1, 0, '0, 0, 0, '0, EXC_PC);
    cycle("prio_next");
    check("prio_next.npc", o_npc, 32'h4184);

    // Misaligned redirect and misaligned ERET target.
    set_in(0, 1, 1, 32'h3042, 0, 0, '0, 32'h4184);
    cycle("mis_redir");
    check("mis_redir.npc", o_npc, EXC_PC);
    check("mis_redir.ae", {31'd0, o_ae}, 32'd1);
    check("mis_redir.fl", {31'd0, o_fl}, 32'd1);
    set_in(0, 1, 0, '0, 0, 0, '0, EXC_PC);
    cycle("mis_after");
    check("mis_after.ae", {31'd0, o_ae}, 32'd0);
    set_in(0, 1, 0, '0, 0, 1, 32'h3001, 32'h4184);
    cycle("mis_eret");
    check("mis_eret.npc", o_npc, EXC_PC);
    check("mis_eret.ae", {31'd0, o_ae}, 32'd1);

    // Watchdog: three held cycles, bus error on the fourth, then back to RUN.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, '0, 0, 0, '0, 32'h5000);
      cycle("tmo_wait");
      check("tmo_wait.npc", o_npc, 32'h5000);
      check("tmo_wait.be", {31'd0, o_be}, 32'd0);
    end
    set_in(0, 0, 0, '0, 0, 0, '0, 32'h5000);
    cycle("tmo_fire");
    check("tmo_fire.npc", o_npc, EXC_PC);
    check("tmo_fire.be", {31'd0, o_be}, 32'd1);
    set_in(0, 1, 0, '0, 0, 0, '0, EXC_PC);
    cycle("tmo_run");
    check("tmo_run.npc", o_npc, 32'h4184);
    check("tmo_run.fv", {31'd0, o_fv}, 32'd1);

    // Sequential fetch wraps at the top of the address space.
    set_in(0, 1, 0, '0, 0, 0, '0, 32'hFFFF_FFFC);
    cycle("wrap");
    check("wrap.npc", o_npc, 32'h0000_0000);
    check("wrap.ae", {31'd0, o_ae}, 32'd0);

    // Reset in the middle of a memory wait with a buffered redirect pending.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 1, 32'h3100, 0, 0, '0, 32'h0);
      cycle("pre_rst");
    end
    #1;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_async");
    @(posedge Clk); #1;
    check_reset_outputs("rst_mid");
    Reset_n = 1'b1;
    set_in(0, 1, 0, '0, 0, 0, '0, 32'h0);
    cycle("reboot");
    check("reboot.npc", o_npc, RST_PC);
    set_in(0, 1, 0, '0, 0, 0, '0, 32'h3000);
    cycle("reboot_fetch");
    check("reboot_fetch.npc", o_npc, 32'h3004);

    // Randomized traffic; Pc follows the modelled NPC like a real PC register.
    pc_next = 32'h3004;
    for (int i = 0; i < 3000; i++) begin
      rt_r  = {$urandom} & 32'hFFFF_FFFC;
      epc_r = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rt_r[1:0]  = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) epc_r[1:0] = 2'($urandom_range(1, 3));
      set_in($urandom_range(0, 3) == 0,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 4) == 0, rt_r,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 29) == 0, epc_r,
             ($urandom_range(0, 19) == 0) ? ({$urandom} & 32'hFFFF_FFFC) : pc_next);
      cycle("rand");
      pc_next = e_npc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
